// File: rtl/hm01b0_mcu_reader_if.sv
// Sample stream from the MCU reader to the DCT stage: one 8-bit sample per
// valid/ready transfer, tagged with block_first / block_last.
interface hm01b0_mcu_reader_if;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       block_first;
  logic       block_last;

  modport master (
    output pix_data,
    output pix_valid,
    output block_first,
    output block_last,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    input  block_first,
    input  block_last,
    output pix_ready
  );
endinterface

// File: rtl/hm01b0_mcu_reader.sv
// Reads a completed 8-line strip out of the back EBR bank as 8x8 MCUs and streams them to the DCT.
// Optional macro MCU_READER_LEVEL_SHIFT_EN: emit (sample - 128) as two's complement instead of raw samples.
module hm01b0_mcu_reader #(
  parameter int NUM_EBRS     = 5,
  parameter int MCUS_PER_EBR = 8
) (
  input  logic                       clock,
  input  logic                       nreset,
  input  logic                       strip_ready,
  input  logic                       frontbuffer_select,
  output logic [2:0]                 ebr_read_select,
  output logic                       ebr_read_bank,
  output logic [8:0]                 ebr_raddr,
  output logic                       ebr_rden,
  input  logic [7:0]                 ebr_rdata,
  hm01b0_mcu_reader_if.master        pix,
  output logic                       strip_done,
  output logic                       busy,
  output logic                       overrun
);

  localparam logic [2:0] LAST_EBR = 3'(NUM_EBRS - 1);
  localparam logic [2:0] LAST_MCU = 3'(MCUS_PER_EBR - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] e_q, e_d;
  logic [2:0] m_q, m_d;
  logic [2:0] r_q, r_d;
  logic [2:0] x_q, x_d;
  logic       bank_q, bank_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       overrun_q, overrun_d;
  logic       inflight_q, inflight_d;
  logic       infl_first_q, infl_first_d;
  logic       infl_last_q, infl_last_d;
  logic [9:0] fifo_q [2];
  logic [9:0] fifo_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  logic       rden;
  logic       pop;
  logic       push;
  logic       last_read;
  logic [2:0] occupancy;
  logic [9:0] head;
  logic [7:0] sample_out;

  always_comb begin
    state_d      = state_q;
    e_d          = e_q;
    m_d          = m_q;
    r_d          = r_q;
    x_d          = x_q;
    bank_d       = bank_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
    fifo_d[0]    = fifo_q[0];
    fifo_d[1]    = fifo_q[1];
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rden         = 1'b0;

    pop       = (count_q != 2'd0) && pix.pix_ready;
    push      = inflight_q;
    count_d   = count_q - {1'b0, pop} + {1'b0, push};
    // A read reserves a FIFO slot now; the slot freed by this cycle's pop is already usable.
    occupancy = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
    last_read = (e_q == LAST_EBR) && (m_q == LAST_MCU) && (r_q == 3'd7) && (x_q == 3'd7);

    unique case (state_q)
      IDLE: begin
        if (strip_ready) begin
          if (done_q) begin
            overrun_d = 1'b1;
          end else begin
            bank_d  = ~frontbuffer_select;
            e_d     = 3'd0;
            m_d     = 3'd0;
            r_d     = 3'd0;
            x_d     = 3'd0;
            busy_d  = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (strip_ready) overrun_d = 1'b1;
        if (occupancy < 3'd2) begin
          rden = 1'b1;
          x_d  = x_q + 3'd1;
          if (x_q == 3'd7) begin
            r_d = r_q + 3'd1;
            if (r_q == 3'd7) begin
              m_d = (m_q == LAST_MCU) ? 3'd0 : m_q + 3'd1;
              if (m_q == LAST_MCU && !last_read) e_d = e_q + 3'd1;
            end
          end
          if (last_read) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (strip_ready) overrun_d = 1'b1;
        // Nothing is issued here, so an empty FIFO next cycle also means nothing in flight.
        if (count_d == 2'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    inflight_d   = rden;
    infl_first_d = rden && (r_q == 3'd0) && (x_q == 3'd0);
    infl_last_d  = rden && (r_q == 3'd7) && (x_q == 3'd7);

    if (push) begin
      fifo_d[wr_ptr_q] = {infl_first_q, infl_last_q, ebr_rdata};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      e_q          <= 3'd0;
      m_q          <= 3'd0;
      r_q          <= 3'd0;
      x_q          <= 3'd0;
      bank_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      inflight_q   <= 1'b0;
      infl_first_q <= 1'b0;
      infl_last_q  <= 1'b0;
      fifo_q[0]    <= 10'd0;
      fifo_q[1]    <= 10'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      e_q          <= e_d;
      m_q          <= m_d;
      r_q          <= r_d;
      x_q          <= x_d;
      bank_q       <= bank_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      inflight_q   <= inflight_d;
      infl_first_q <= infl_first_d;
      infl_last_q  <= infl_last_d;
      fifo_q[0]    <= fifo_d[0];
      fifo_q[1]    <= fifo_d[1];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign head = fifo_q[rd_ptr_q];

`ifdef MCU_READER_LEVEL_SHIFT_EN
  assign sample_out = head[7:0] ^ 8'h80;
`else
  assign sample_out = head[7:0];
`endif

  assign ebr_read_select = e_q;
  assign ebr_read_bank   = bank_q;
  assign ebr_raddr       = {r_q, m_q, x_q};
  assign ebr_rden        = rden;

  assign pix.pix_valid   = (count_q != 2'd0);
  assign pix.pix_data    = (count_q != 2'd0) ? sample_out : 8'h00;
  assign pix.block_first = (count_q != 2'd0) && head[9];
  assign pix.block_last  = (count_q != 2'd0) && head[8];

  assign strip_done = done_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_hm01b0_mcu_reader.sv
// Directed bench for hm01b0_mcu_reader: EBR model, sample-order model, backpressure,
// overrun, mid-strip reset and back-to-back strips.
module tb_hm01b0_mcu_reader;

  logic       clock;
  logic       nreset;
  logic       strip_ready;
  logic       frontbuffer_select;
  logic [2:0] ebr_read_select;
  logic       ebr_read_bank;
  logic [8:0] ebr_raddr;
  logic       ebr_rden;
  logic [7:0] ebr_rdata;
  logic       strip_done;
  logic       busy;
  logic       overrun;

  hm01b0_mcu_reader_if pix_if ();

  hm01b0_mcu_reader #(
    .NUM_EBRS    (5),
    .MCUS_PER_EBR(8)
  ) dut (
    .clock             (clock),
    .nreset            (nreset),
    .strip_ready       (strip_ready),
    .frontbuffer_select(frontbuffer_select),
    .ebr_read_select   (ebr_read_select),
    .ebr_read_bank     (ebr_read_bank),
    .ebr_raddr         (ebr_raddr),
    .ebr_rden          (ebr_rden),
    .ebr_rdata         (ebr_rdata),
    .pix               (pix_if),
    .strip_done        (strip_done),
    .busy              (busy),
    .overrun           (overrun)
  );

  logic [7:0] ebr_mem [2][5][512];

  int   tests_run = 0;
  int   tests_failed = 0;
  int   cycle_cnt = 0;
  int   strip_id = 0;
  logic exp_bank = 1'b0;
  logic bp_mode = 1'b0;
  int   start_cycle = 0;
  int   sample_idx = 0;
  int   done_count = 0;
  int   done_cycle = 0;
  int   first_valid_cycle = 0;
  logic seen_valid = 1'b0;
  logic [7:0] s0, s16, s64, s511;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  // Synchronous EBR: data for a strobe appears in the following cycle.
  always @(posedge clock) begin
    if (ebr_rden) ebr_rdata <= ebr_mem[ebr_read_bank][ebr_read_select][ebr_raddr];
  end

  initial begin
    pix_if.pix_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      pix_if.pix_ready = bp_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] shiftExp(input logic [7:0] raw);
`ifdef MCU_READER_LEVEL_SHIFT_EN
    return raw ^ 8'h80;
`else
    return raw;
`endif
  endfunction

  // Sample n of a strip: block n/64 -> (ebr, mcu); within block -> (row, col).
  function automatic logic [9:0] expSample(input int n, input logic bank);
    int blk, e, m, w, r, x, addr;
    logic [7:0] raw;
    blk  = n / 64;
    e    = blk / 8;
    m    = blk % 8;
    w    = n % 64;
    r    = w / 8;
    x    = w % 8;
    addr = r * 64 + m * 8 + x;
    raw  = addr[7:0] ^ e[7:0];
    if (!bank) raw = raw ^ 8'h5A;
    return {(w == 0), (w == 63), shiftExp(raw)};
  endfunction

  function automatic logic [27:0] allOutputs();
    return {ebr_read_select, ebr_read_bank, ebr_raddr, ebr_rden, pix_if.pix_data,
            pix_if.pix_valid, pix_if.block_first, pix_if.block_last, strip_done, busy, overrun};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic fb);
    frontbuffer_select = fb;
    strip_ready        = 1'b1;
    exp_bank           = ~fb;
    strip_id++;
    tick();
    strip_ready = 1'b0;
    start_cycle = cycle_cnt;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (strip_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (strip_done !== 1'b1) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitSamples(input int target, input int budget);
    int n = 0;
    while (sample_idx < target && n < budget) begin
      tick();
      n++;
    end
    if (sample_idx < target) checkOutput("sample_wait_timeout", sample_idx, target);
  endtask

  // Accepted samples are checked against the model; stalled heads must not change.
  task automatic runMonitor();
    logic [9:0] got;
    logic [9:0] held;
    logic       stall_pending;
    int         last_id;
    stall_pending = 1'b0;
    held          = '0;
    last_id       = 0;
    forever begin
      @(negedge clock);
      if (strip_id != last_id) begin
        last_id       = strip_id;
        sample_idx    = 0;
        seen_valid    = 1'b0;
        stall_pending = 1'b0;
      end
      if (!nreset) stall_pending = 1'b0;
      if (strip_done) begin
        done_count++;
        done_cycle = cycle_cnt;
      end
      got = {pix_if.block_first, pix_if.block_last, pix_if.pix_data};
      if (pix_if.pix_valid) begin
        if (!seen_valid) begin
          seen_valid        = 1'b1;
          first_valid_cycle = cycle_cnt;
        end
        if (stall_pending) checkOutput("stall_hold", got, held);
        if (pix_if.pix_ready) begin
          checkOutput($sformatf("sample%0d", sample_idx), got, expSample(sample_idx, exp_bank));
          if (sample_idx == 0)   s0   = got[7:0];
          if (sample_idx == 16)  s16  = got[7:0];
          if (sample_idx == 64)  s64  = got[7:0];
          if (sample_idx == 511) s511 = got[7:0];
          sample_idx++;
          stall_pending = 1'b0;
        end else begin
          stall_pending = 1'b1;
          held          = got;
        end
      end else if (stall_pending) begin
        checkOutput("stall_valid_dropped", 32'd0, 32'd1);
        stall_pending = 1'b0;
      end
    end
  endtask

  initial begin
    int done_before;
    fork
      runMonitor();
    join_none

    nreset             = 1'b0;
    strip_ready        = 1'b0;
    frontbuffer_select = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int e = 0; e < 5; e++)
        for (int a = 0; a < 512; a++)
          ebr_mem[b][e][a] = a[7:0] ^ e[7:0] ^ ((b == 0) ? 8'h5A : 8'h00);

    repeat (3) tick();
    checkOutput("reset_outputs", allOutputs(), 32'd0);
    nreset = 1'b1;
    repeat (2) tick();

    // Strip 1: full rate, read bank opposite frontbuffer 0
    done_before = done_count;
    applyStimulus(1'b0);
    checkOutput("bank_latch", ebr_read_bank, 1'b1);
    checkOutput("busy_start", busy, 1'b1);
    checkOutput("first_strobe", ebr_rden, 1'b1);
    waitDone(6000);
    tick();
    checkOutput("done_latency", done_cycle - start_cycle, 32'd2562);
    checkOutput("first_valid_latency", first_valid_cycle - start_cycle, 32'd2);
    checkOutput("run1_count", sample_idx, 32'd2560);
    checkOutput("run1_done_once", done_count - done_before, 32'd1);
    checkOutput("run1_busy_end", busy, 1'b0);
    checkOutput("run1_overrun", overrun, 1'b0);
    checkOutput("byte00", s0, shiftExp(8'h00));
    checkOutput("byte80", s16, shiftExp(8'h80));
    checkOutput("byteFF", s511, shiftExp(8'hFF));
    checkOutput("sample64_addr8", s64, shiftExp(8'h08));
`ifdef MCU_READER_LEVEL_SHIFT_EN
    checkOutput("shift_00", s0, 8'h80);
    checkOutput("shift_FF", s511, 8'h7F);
    checkOutput("shift_80", s16, 8'h00);
`endif

    // Strip 2: random backpressure
    bp_mode     = 1'b1;
    done_before = done_count;
    applyStimulus(1'b0);
    waitDone(30000);
    bp_mode = 1'b0;
    tick();
    checkOutput("bp_count", sample_idx, 32'd2560);
    checkOutput("bp_done_once", done_count - done_before, 32'd1);

    // Strip 3: strip_ready while busy
    repeat (3) tick();
    done_before = done_count;
    applyStimulus(1'b0);
    waitSamples(1000, 3000);
    strip_ready        = 1'b1;
    frontbuffer_select = 1'b1;
    tick();
    strip_ready        = 1'b0;
    frontbuffer_select = 1'b0;
    checkOutput("overrun_set", overrun, 1'b1);
    checkOutput("overrun_bank_kept", ebr_read_bank, 1'b1);
    waitDone(6000);
    tick();
    checkOutput("overrun_count", sample_idx, 32'd2560);
    repeat (20) tick();
    checkOutput("overrun_no_restart", {busy, pix_if.pix_valid, ebr_rden}, 3'b000);
    checkOutput("overrun_done_once", done_count - done_before, 32'd1);

    // Strip 4: reset mid-strip, then restart
    done_before = done_count;
    applyStimulus(1'b0);
    waitSamples(500, 3000);
    nreset = 1'b0;
    #1;
    checkOutput("abort_outputs", allOutputs(), 32'd0);
    repeat (3) tick();
    nreset = 1'b1;
    tick();
    applyStimulus(1'b0);
    checkOutput("restart_overrun", overrun, 1'b0);
    checkOutput("restart_raddr", ebr_raddr, 9'd0);
    waitDone(6000);
    tick();
    checkOutput("restart_count", sample_idx, 32'd2560);
    checkOutput("abort_no_done", done_count - done_before, 32'd1);

    // Strip 5: one cycle after strip_done, following frontbuffer 1
    done_before = done_count;
    applyStimulus(1'b1);
    checkOutput("b2b_bank", ebr_read_bank, 1'b0);
    checkOutput("b2b_busy", busy, 1'b1);
    waitDone(6000);
    checkOutput("b2b_overrun", overrun, 1'b0);

    // strip_ready during the strip_done cycle is an overrun
    strip_ready        = 1'b1;
    frontbuffer_select = 1'b0;
    tick();
    strip_ready = 1'b0;
    checkOutput("samecycle_overrun", overrun, 1'b1);
    checkOutput("samecycle_not_started", {busy, ebr_rden}, 2'b00);
    checkOutput("samecycle_bank", ebr_read_bank, 1'b0);
    checkOutput("b2b_count", sample_idx, 32'd2560);
    checkOutput("b2b_done_once", done_count - done_before, 32'd1);
    repeat (5) tick();
    checkOutput("samecycle_idle", {busy, pix_if.pix_valid}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hm01b0_mcu_reader.md
Name: hm01b0_mcu_reader

Overview:
- Downstream neighbour of hm01b0_ingester.
- Once the ingester has filled one 8-line strip into one EBR bank, this block reads that bank back as 8x8 MCUs and streams 64 samples per block to the DCT stage through a valid/ready interface.
- It reads the bank the ingester is not writing.
- It sits between the ten-EBR double buffer (two banks of NUM_EBRS) and the JPEG transform pipeline.

Parameters:
- NUM_EBRS, 5: EBRs per bank. Each EBR holds 8 rows x 64 columns.
- MCUS_PER_EBR, 8: 8x8 blocks per EBR. Fixed by 512-byte EBR / 64 bytes per block.

Ports:
- clock  in  1  system clock.
- nreset  in  1  asynchronous active-low reset.
- strip_ready  in  1  one-cycle pulse from the ingester: a strip is complete in the bank opposite frontbuffer_select.
- frontbuffer_select  in  1  bank the ingester is currently writing.
- ebr_read_select  out  3  EBR index 0..NUM_EBRS-1 being read.
- ebr_read_bank  out  1  bank being read (0: EBRs 0-4, 1: EBRs 5-9).
- ebr_raddr  out  9  EBR read address.
- ebr_rden  out  1  read strobe. Data for a strobe arrives on ebr_rdata in the following cycle.
- ebr_rdata  in  8  muxed EBR read data.
- pix_data  out  8  output sample.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  downstream accepts the sample when pix_valid && pix_ready.
- block_first  out  1  qualifies sample 0 of a block.
- block_last  out  1  qualifies sample 63 of a block.
- strip_done  out  1  one-cycle pulse after the last sample of the strip is accepted.
- busy  out  1  high from strip start until strip_done.
- overrun  out  1  sticky flag: strip_ready arrived while busy. Cleared only by reset.

Behaviour:
- Reset (async, nreset low):
  - state IDLE.
  - All outputs 0, ebr_read_bank 0.
  - FIFO empty, counters 0.
  - Asserting reset mid-strip aborts the strip immediately. No strip_done is produced.
- Bank latch:
  - On strip_ready in IDLE: ebr_read_bank <= ~frontbuffer_select, counters cleared, busy <= 1, state FETCH.
- Read order, as nested counters from outermost to innermost:
  - ebr e: 0..NUM_EBRS-1
  - mcu m: 0..7
  - row r: 0..7
  - column x: 0..7
  - ebr_raddr = r*64 + m*8 + x (that is {r[2:0], m[2:0], x[2:0]}); ebr_read_select = e.
  - Block index = e*8 + m, so 40 blocks and 2560 samples per strip.
- Output buffer:
  - 2-entry FIFO in front of pix_data.
  - A read is issued (ebr_rden = 1) in FETCH only when FIFO count + reads in flight < 2.
  - The sample is written into the FIFO in the cycle after the strobe.
  - Guarantees no loss under arbitrary pix_ready. Sustained throughput is 1 sample/cycle when pix_ready is held high.
  - pix_data, block_first and block_last are taken from the FIFO head. They hold stable while pix_valid && !pix_ready.
  - block_first/block_last are stored with each entry: first when r=0,x=0; last when r=7,x=7.
- FSM:
  - IDLE -> FETCH on strip_ready.
  - FETCH -> DRAIN after the read with e=NUM_EBRS-1, m=7, r=7, x=7 is issued.
  - DRAIN -> IDLE when the FIFO is empty and nothing is in flight. strip_done pulses on that transition and busy drops in the same cycle.
- strip_ready while busy:
  - Ignored and overrun <= 1.
  - strip_ready in the same cycle as strip_done (DRAIN->IDLE) also counts as overrun and is not started.
- Counter wrap: x, r and m wrap 7->0 and carry outward. e does not wrap; the transition to DRAIN stops reads.
- Latency: first pix_valid appears 2 cycles after strip_ready (cycle 1 strobe, cycle 2 data in FIFO and visible).

Optional Feature:
- Macro MCU_READER_LEVEL_SHIFT_EN.
- Defined: pix_data = stored sample XOR 8'h80, i.e. the two's-complement value (sample - 128) that the DCT expects.
- Undefined: pix_data is the raw unsigned sample.
- Timing and handshake are identical in both cases.

Test Plan:
- Reset, then strip_ready with frontbuffer_select=0, pix_ready held 1, EBRs preloaded with mem[a] = a[7:0] ^ e:
  - ebr_read_bank = 1.
  - 2560 samples; first sample 0x00 with block_first.
  - sample 64 (block 1) = mem addr 8; block_last on every 64th sample.
  - strip_done exactly once, 2562 cycles after strip_ready.
- Backpressure: pix_ready toggled with a pseudo-random 30% duty:
  - sample sequence identical to the previous run.
  - no duplicates or drops.
  - pix_data stable while stalled.
- strip_ready pulsed at sample 1000 of a strip:
  - overrun = 1.
  - strip still completes with 2560 samples.
  - no second strip starts.
- nreset pulsed low at sample 500:
  - all outputs 0 immediately.
  - a new strip_ready afterwards restarts at block 0, sample 0, with overrun = 0.
- MCU_READER_LEVEL_SHIFT_EN defined, EBR byte 0x00 -> pix_data 0x80; 0xFF -> 0x7F; 0x80 -> 0x00.
- Back-to-back strips: second strip_ready issued 1 cycle after strip_done:
  - accepted.
  - bank follows the new frontbuffer_select.
  - overrun stays 0.
